// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage between EX and writeback: one-cycle pass-through for
// non-memory ops, req/ack handshake with bus timeout for LOAD/STORE.
module mem_access_stage #(
  parameter int unsigned           DATA_W         = 16,
  parameter int unsigned           ADDR_W         = 16,
  parameter int unsigned           REG_IDX_W      = 5,
  parameter int unsigned           CTRL_W         = 4,
  parameter logic [CTRL_W-1:0]     LOAD_OP        = 4'b1100,
  parameter logic [CTRL_W-1:0]     STORE_OP       = 4'b1110,
  parameter int unsigned           TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  input  logic [CTRL_W-1:0]    control_ex,
  input  logic [DATA_W-1:0]    result_ex,
  input  logic [DATA_W-1:0]    reg_data_ex,
  input  logic [REG_IDX_W-1:0] dest_reg_index_ex,
  input  logic                 dest_reg_write_en_ex,
  output logic                 stall_ex,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    address_to_memory,
  output logic [DATA_W-1:0]    data_to_memory,
  input  logic                 mem_ack,
  input  logic [DATA_W-1:0]    data_from_memory,
  output logic                 ma_valid,
  output logic [CTRL_W-1:0]    control_ma,
  output logic [DATA_W-1:0]    result_ma,
  output logic [DATA_W-1:0]    data_ma,
  output logic [REG_IDX_W-1:0] dest_reg_index_ma,
  output logic                 dest_reg_write_en_ma,
  output logic                 mem_err_ma
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic                   is_mem_op;
  logic                   timeout_hit;
  logic                   accept_mem, accept_pass, complete_ack, complete_abort;

  logic [CTRL_W-1:0]      lat_control;
  logic [DATA_W-1:0]      lat_result;
  logic [REG_IDX_W-1:0]   lat_index;
  logic                   lat_write_en;
  logic                   lat_store;

  assign stall_ex = (state == ACCESS);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    accept_mem     = 1'b0;
    accept_pass    = 1'b0;
    complete_ack   = 1'b0;
    complete_abort = 1'b0;
    is_mem_op      = (control_ex == LOAD_OP) || (control_ex == STORE_OP);
    timeout_hit    = (TIMEOUT_CYCLES != 0) && (cnt == LAST_CNT);
    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (is_mem_op) begin
            accept_mem = 1'b1;
            state_nxt  = ACCESS;
          end else begin
            accept_pass = 1'b1;
          end
        end
      end
      ACCESS: begin
        // Ack wins over a timeout landing on the same edge.
        if (mem_ack) begin
          complete_ack = 1'b1;
          state_nxt    = IDLE;
        end else if (timeout_hit) begin
          complete_abort = 1'b1;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counts ACCESS cycles without ack; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n)                            cnt <= '0;
    else if (accept_mem)                   cnt <= '0;
    else if (state == ACCESS && cnt != '1) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_req           <= 1'b0;
      mem_we            <= 1'b0;
      address_to_memory <= '0;
      data_to_memory    <= '0;
      lat_control       <= '0;
      lat_result        <= '0;
      lat_index         <= '0;
      lat_write_en      <= 1'b0;
      lat_store         <= 1'b0;
    end else if (accept_mem) begin
      mem_req           <= 1'b1;
      mem_we            <= (control_ex == STORE_OP);
      address_to_memory <= result_ex[ADDR_W-1:0];
      data_to_memory    <= reg_data_ex;
      lat_control       <= control_ex;
      lat_result        <= result_ex;
      lat_index         <= dest_reg_index_ex;
      lat_write_en      <= dest_reg_write_en_ex;
      lat_store         <= (control_ex == STORE_OP);
    end else if (complete_ack || complete_abort) begin
      mem_req           <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ma_valid             <= 1'b0;
      control_ma           <= '0;
      result_ma            <= '0;
      data_ma              <= '0;
      dest_reg_index_ma    <= '0;
      dest_reg_write_en_ma <= 1'b0;
      mem_err_ma           <= 1'b0;
    end else begin
      ma_valid <= accept_pass || complete_ack || complete_abort;
      if (accept_pass) begin
        control_ma           <= control_ex;
        result_ma            <= result_ex;
        data_ma              <= '0;
        dest_reg_index_ma    <= dest_reg_index_ex;
        dest_reg_write_en_ma <= dest_reg_write_en_ex;
        mem_err_ma           <= 1'b0;
      end else if (complete_ack) begin
        control_ma           <= lat_control;
        result_ma            <= lat_result;
        data_ma              <= lat_store ? '0 : data_from_memory;
        dest_reg_index_ma    <= lat_index;
        dest_reg_write_en_ma <= lat_write_en && !lat_store;
        mem_err_ma           <= 1'b0;
      end else if (complete_abort) begin
        control_ma           <= lat_control;
        result_ma            <= lat_result;
        data_ma              <= '0;
        dest_reg_index_ma    <= lat_index;
        dest_reg_write_en_ma <= 1'b0;
        mem_err_ma           <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: transaction-level model compared every cycle,
// plus literal checks at the points of interest.
module tb_mem_access_stage;

  localparam int unsigned TO       = 4;
  localparam logic [3:0]  LOAD_OP  = 4'b1100;
  localparam logic [3:0]  STORE_OP = 4'b1110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [3:0]  control_ex;
  logic [15:0] result_ex, reg_data_ex;
  logic [4:0]  dest_reg_index_ex;
  logic        dest_reg_write_en_ex;
  logic        stall_ex, mem_req, mem_we;
  logic [15:0] address_to_memory, data_to_memory;
  logic        mem_ack;
  logic [15:0] data_from_memory;
  logic        ma_valid;
  logic [3:0]  control_ma;
  logic [15:0] result_ma, data_ma;
  logic [4:0]  dest_reg_index_ma;
  logic        dest_reg_write_en_ma, mem_err_ma;

  int n_vec = 0;
  int n_mis = 0;

  mem_access_stage #(
    .DATA_W(16), .ADDR_W(16), .REG_IDX_W(5), .CTRL_W(4),
    .LOAD_OP(LOAD_OP), .STORE_OP(STORE_OP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .control_ex(control_ex),
    .result_ex(result_ex), .reg_data_ex(reg_data_ex),
    .dest_reg_index_ex(dest_reg_index_ex), .dest_reg_write_en_ex(dest_reg_write_en_ex),
    .stall_ex(stall_ex), .mem_req(mem_req), .mem_we(mem_we),
    .address_to_memory(address_to_memory), .data_to_memory(data_to_memory),
    .mem_ack(mem_ack), .data_from_memory(data_from_memory),
    .ma_valid(ma_valid), .control_ma(control_ma), .result_ma(result_ma),
    .data_ma(data_ma), .dest_reg_index_ma(dest_reg_index_ma),
    .dest_reg_write_en_ma(dest_reg_write_en_ma), .mem_err_ma(mem_err_ma)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding op, counted in elapsed ACCESS cycles.
  logic        checking = 1'b0;
  logic        busy = 1'b0;
  int          elapsed = 0;
  logic [3:0]  op_ctl;
  logic [15:0] op_res;
  logic [4:0]  op_idx;
  logic        op_we, op_store;
  logic        e_req, e_we, e_valid, e_wen, e_err;
  logic [15:0] e_addr, e_wd, e_res, e_data;
  logic [3:0]  e_ctl;
  logic [4:0]  e_idx;

  always @(posedge clk) begin
    checking = 1'b1;
    if (!rst_n) begin
      busy = 0; e_req = 0; e_we = 0; e_addr = 0; e_wd = 0; e_valid = 0;
      e_ctl = 0; e_res = 0; e_data = 0; e_idx = 0; e_wen = 0; e_err = 0;
    end else if (!busy) begin
      e_valid = 0;
      if (ex_valid) begin
        if (control_ex == LOAD_OP || control_ex == STORE_OP) begin
          busy = 1; elapsed = 0;
          op_ctl = control_ex; op_res = result_ex; op_idx = dest_reg_index_ex;
          op_we = dest_reg_write_en_ex; op_store = (control_ex == STORE_OP);
          e_req = 1; e_we = op_store; e_addr = result_ex; e_wd = reg_data_ex;
        end else begin
          e_valid = 1; e_ctl = control_ex; e_res = result_ex; e_data = 0;
          e_idx = dest_reg_index_ex; e_wen = dest_reg_write_en_ex; e_err = 0;
        end
      end
    end else begin
      elapsed++;
      if (mem_ack || (TO != 0 && elapsed == int'(TO))) begin
        busy = 0; e_req = 0; e_valid = 1;
        e_ctl = op_ctl; e_res = op_res; e_idx = op_idx;
        e_err  = !mem_ack;
        e_data = (mem_ack && !op_store) ? data_from_memory : 16'h0;
        e_wen  = mem_ack && !op_store && op_we;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("stall_ex", stall_ex, busy);
      chk("mem_req", mem_req, e_req);
      if (e_req) begin
        chk("mem_we", mem_we, e_we);
        chk("address", address_to_memory, e_addr);
        chk("wdata", data_to_memory, e_wd);
      end
      chk("ma_valid", ma_valid, e_valid);
      if (e_valid) begin
        chk("control_ma", control_ma, e_ctl);
        chk("result_ma", result_ma, e_res);
        chk("data_ma", data_ma, e_data);
        chk("index_ma", dest_reg_index_ma, e_idx);
        chk("wen_ma", dest_reg_write_en_ma, e_wen);
        chk("err_ma", mem_err_ma, e_err);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] c, input logic [15:0] r, input logic [15:0] d,
                       input logic [4:0] i, input logic w);
    ex_valid = 1; control_ex = c; result_ex = r; reg_data_ex = d;
    dest_reg_index_ex = i; dest_reg_write_en_ex = w;
  endtask

  initial begin
    rst_n = 0; mem_ack = 0; data_from_memory = 0;
    issue(LOAD_OP, 16'd12, 16'd0, 5'd1, 1'b1);
    step(); step();
    chk("rst mem_req", mem_req, 0);
    chk("rst stall", stall_ex, 0);
    chk("rst ma_valid", ma_valid, 0);
    chk("rst addr", address_to_memory, 0);
    chk("rst wdata", data_to_memory, 0);
    chk("rst result_ma", result_ma, 0);
    chk("rst err", mem_err_ma, 0);
    rst_n = 1; ex_valid = 0;
    step();

    // ALU pass-through then a full-rate stream
    issue(4'b0001, 16'd12, 16'd0, 5'd3, 1'b1);
    step();
    chk("alu valid", ma_valid, 1);
    chk("alu result", result_ma, 12);
    chk("alu data", data_ma, 0);
    chk("alu wen", dest_reg_write_en_ma, 1);
    chk("alu stall", stall_ex, 0);
    for (int i = 0; i < 3; i++) begin
      issue(4'b0010, 16'(100 + i), 16'd0, 5'(i), i[0]);
      step();
      chk("stream valid", ma_valid, 1);
      chk("stream result", result_ma, 32'(100 + i));
    end
    ex_valid = 0;
    step();

    // Load with 3-cycle memory; EX input changes during ACCESS must be ignored
    issue(LOAD_OP, 16'd12, 16'd0, 5'd5, 1'b1);
    step();
    chk("ld req c1", mem_req, 1);
    chk("ld addr c1", address_to_memory, 12);
    chk("ld stall c1", stall_ex, 1);
    issue(4'b0001, 16'd99, 16'd0, 5'd8, 1'b1);
    step();
    chk("ld req c2", mem_req, 1);
    ex_valid = 0;
    step();
    chk("ld req c3", mem_req, 1);
    mem_ack = 1; data_from_memory = 16'd14;
    step();
    mem_ack = 0;
    chk("ld valid", ma_valid, 1);
    chk("ld data", data_ma, 14);
    chk("ld wen", dest_reg_write_en_ma, 1);
    chk("ld req done", mem_req, 0);

    // Store acked in its first ACCESS cycle
    issue(STORE_OP, 16'd10, 16'd13, 5'd7, 1'b1);
    step();
    ex_valid = 0;
    chk("st we", mem_we, 1);
    chk("st addr", address_to_memory, 10);
    chk("st wdata", data_to_memory, 13);
    mem_ack = 1;
    step();
    mem_ack = 0;
    chk("st valid", ma_valid, 1);
    chk("st wen", dest_reg_write_en_ma, 0);
    chk("st req", mem_req, 0);

    // Timeout: no ack for TO cycles, then a late ack in IDLE
    issue(LOAD_OP, 16'd20, 16'd0, 5'd9, 1'b1);
    step();
    ex_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to req held", mem_req, 1);
    end
    step();
    chk("to valid", ma_valid, 1);
    chk("to err", mem_err_ma, 1);
    chk("to wen", dest_reg_write_en_ma, 0);
    chk("to req", mem_req, 0);
    mem_ack = 1; data_from_memory = 16'd77;
    step();
    mem_ack = 0;
    chk("late ack valid", ma_valid, 0);
    chk("late ack stall", stall_ex, 0);

    // Ack on the final allowed cycle beats the timeout
    issue(LOAD_OP, 16'd21, 16'd0, 5'd4, 1'b1);
    step();
    ex_valid = 0;
    step(); step(); step();
    mem_ack = 1; data_from_memory = 16'h1234;
    step();
    mem_ack = 0;
    chk("edge ack valid", ma_valid, 1);
    chk("edge ack err", mem_err_ma, 0);
    chk("edge ack data", data_ma, 16'h1234);

    // Alternating load/store, then reset in the middle of an access
    issue(LOAD_OP, 16'd11, 16'd0, 5'd2, 1'b1);
    step();
    ex_valid = 0; mem_ack = 1; data_from_memory = 16'h55;
    step();
    mem_ack = 0;
    chk("alt ld data", data_ma, 16'h55);
    chk("alt ld result", result_ma, 11);
    issue(STORE_OP, 16'd10, 16'h33, 5'd6, 1'b1);
    step();
    ex_valid = 0; mem_ack = 1;
    chk("alt st addr", address_to_memory, 10);
    step();
    mem_ack = 0;
    chk("alt st valid", ma_valid, 1);
    chk("alt st wen", dest_reg_write_en_ma, 0);
    issue(LOAD_OP, 16'd11, 16'd0, 5'd2, 1'b1);
    step();
    ex_valid = 0;
    step();
    rst_n = 0;
    step();
    chk("mid rst req", mem_req, 0);
    chk("mid rst valid", ma_valid, 0);
    chk("mid rst stall", stall_ex, 0);
    rst_n = 1; mem_ack = 1;
    step();
    mem_ack = 0;
    chk("post rst ack valid", ma_valid, 0);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Parametrised memory-access (MA) pipeline stage of the pipelined core. It sits between EX and writeback. It replaces the fixed single-cycle memory stage with a req/ack handshake to a variable-latency data memory, and adds an EX-side stall and a bus-timeout error. Non-memory ops pass through with one-cycle latency; LOAD/STORE hold the stage until memory acknowledges or the timeout expires.

Parameters:
DATA_W, 16, data and result width
ADDR_W, 16, memory address width; address = result_ex[ADDR_W-1:0]
REG_IDX_W, 5, destination register index width
CTRL_W, 4, control/opcode field width
LOAD_OP, 4'b1100, control encoding for load
STORE_OP, 4'b1110, control encoding for store
TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort; 0 disables timeout

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
ex_valid  in  1  EX presents a valid op this cycle
control_ex  in  CTRL_W  op control from EX
result_ex  in  DATA_W  ALU result / effective address
reg_data_ex  in  DATA_W  store data
dest_reg_index_ex  in  REG_IDX_W  destination register
dest_reg_write_en_ex  in  1  register write enable from EX
stall_ex  out  1  EX must hold its current op
mem_req  out  1  memory request, held until ack or abort
mem_we  out  1  1 = store, 0 = load; valid with mem_req
address_to_memory  out  ADDR_W  request address
data_to_memory  out  DATA_W  store data
mem_ack  in  1  memory completion, single-cycle pulse
data_from_memory  in  DATA_W  load data, valid with mem_ack
ma_valid  out  1  one-cycle pulse, MA outputs carry a completed op
control_ma  out  CTRL_W  control of completed op
result_ma  out  DATA_W  result_ex of completed op
data_ma  out  DATA_W  load data; 0 for non-load
dest_reg_index_ma  out  REG_IDX_W  destination register
dest_reg_write_en_ma  out  1  register write enable to writeback
mem_err_ma  out  1  completed op aborted by timeout

Behaviour:
- Reset (rst_n low at an edge): state=IDLE; timeout counter=0. Every output is 0: stall_ex, mem_req, mem_we, address, wdata, ma_valid, all *_ma fields and mem_err_ma. Reset takes priority over all other events.
- FSM states: IDLE and ACCESS.
- stall_ex = (state==ACCESS), combinational from state.
- IDLE, ex_valid=0: ma_valid<=0; all other *_ma hold.
- IDLE, ex_valid=1, control_ex not LOAD_OP/STORE_OP (pass-through):
  - next edge: ma_valid<=1; control/result/index/write_en copied; data_ma<=0; mem_err_ma<=0.
  - Latency is 1 cycle; a back-to-back stream runs at full rate.
- IDLE, ex_valid=1, control_ex == LOAD_OP or STORE_OP:
  - Latch all EX fields, address<=result_ex, data_to_memory<=reg_data_ex, mem_we<=(STORE).
  - mem_req<=1, counter<=0, ma_valid<=0, state<=ACCESS.
- ACCESS, mem_ack=1:
  - mem_req<=0, state<=IDLE, ma_valid<=1, mem_err_ma<=0.
  - Load: data_ma<=data_from_memory; dest_reg_write_en_ma<=latched enable.
  - Store: data_ma<=0; dest_reg_write_en_ma<=0 (forced).
- ACCESS, mem_ack=0:
  - counter increments.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without ack, the op aborts on that edge: mem_req<=0, state<=IDLE, ma_valid<=1, mem_err_ma<=1, dest_reg_write_en_ma<=0, data_ma<=0.
  - Ack takes priority over timeout on the same edge.
- Latency: ack sampled k edges after acceptance gives ma_valid k edges after acceptance (k>=1). The next EX op is accepted on the edge after completion.
- mem_req, mem_we, address and wdata are stable for the whole ACCESS period.
- mem_ack sampled in IDLE, including a late ack after an abort or reset, is ignored.
- Reset mid-ACCESS: mem_req drops at that edge. The in-flight op is discarded with no ma_valid.
- Counter width is clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- ex_valid is ignored while in ACCESS; EX holds its op because stall_ex is high.

Test Plan:
- Reset: rst_n=0 for 2 cycles with ex_valid=1, LOAD -> all outputs 0, mem_req never asserted.
- ALU pass-through: control_ex=4'b0001, result_ex=12, idx=3, we=1 -> next cycle ma_valid=1, result_ma=12, data_ma=0, write_en_ma=1, stall_ex=0.
- Load, 3-cycle memory: LOAD, result_ex=12, ack on 3rd ACCESS cycle with data=14 ->
  - mem_req=1 and address=12 for 3 cycles; stall_ex=1 for 3 cycles;
  - ma_valid=1, data_ma=14, write_en_ma=1.
- Store, ack in first cycle: STORE, result_ex=10, reg_data_ex=13 -> one cycle with mem_req=1, mem_we=1, addr=10, wdata=13; then ma_valid=1, write_en_ma=0.
- Timeout: TIMEOUT_CYCLES=4, LOAD, no ack ->
  - mem_req high 4 cycles, then ma_valid=1, mem_err_ma=1, write_en_ma=0;
  - a late ack in IDLE is ignored.
- Alternating LOAD(addr 11)/STORE(addr 10) with ack at 1 cycle, then rst_n=0 during 2nd ACCESS -> ops complete in order; mem_req=0 and no ma_valid after reset.
